fetch_unit: RTL and testbench

- LC2K instruction-fetch stage, directly upstream of the instruction memory.
- Owns the program counter and drives pcCurrent into the memory, which returns instr combinationally in the same cycle.
- Captures the fetched word into an IF/ID pipeline register for the decoder.
- Handles stall, branch/jalr redirect with flush, and speculative halt detection.

---
 rtl/lc2k_pkg.sv | 41 ++++
 rtl/fetch_unit_if_id_reg.sv | 35 +++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: opcode constants, instruction field positions,
// the fetch FSM state encoding and a halt-detect helper.
package lc2k_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPCODE_W   = 3;
    localparam int unsigned OPCODE_LSB = 22;
    localparam int unsigned OPCODE_MSB = 24;
    localparam int unsigned REGA_LSB   = 19;
    localparam int unsigned REGB_LSB   = 16;
    localparam int unsigned OFFSET_W   = 16;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OPCODE_W-1:0] OP_NOR  = 3'd1;
    localparam logic [OPCODE_W-1:0] OP_LW   = 3'd2;
    localparam logic [OPCODE_W-1:0] OP_SW   = 3'd3;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 3'd4;
    localparam logic [OPCODE_W-1:0] OP_JALR = 3'd5;
    localparam logic [OPCODE_W-1:0] OP_HALT = 3'd6;
    localparam logic [OPCODE_W-1:0] OP_NOOP = 3'd7;

    // Field layout of one instruction word, for the decoder's benefit.
    typedef struct packed {
        logic [6:0]          unused;
        logic [OPCODE_W-1:0] opcode;
        logic [2:0]          reg_a;
        logic [2:0]          reg_b;
        logic [OFFSET_W-1:0] offset;
    } lc2k_instr_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } fetch_state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: fetched instruction, fetch PC + 1 and valid bit.
// Ports: clk, rstN, load (capture new word), flush (drop valid, keep data),
//        instrIn/pcPlus1In (capture data), ifInstr/ifPcPlus1/ifValid (register).
module if_id_reg
    import lc2k_pkg::*;
#(
    parameter int unsigned PC_W = 16
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instrIn,
    input  logic [PC_W-1:0]    pcPlus1In,
    output logic [INSTR_W-1:0] ifInstr,
    output logic [PC_W-1:0]    ifPcPlus1,
    output logic               ifValid
);

    // Flush wins over load; neither means hold.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ifInstr   <= '0;
            ifPcPlus1 <= '0;
            ifValid   <= 1'b0;
        end else if (flush) begin
            ifValid   <= 1'b0;
        end else if (load) begin
            ifInstr   <= instrIn;
            ifPcPlus1 <= pcPlus1In;
            ifValid   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// LC2K instruction-fetch stage: owns the PC, drives the instruction memory,
// captures the returned word into IF/ID, handles stall, redirect/flush and
// speculative halt. Optional FETCH_BOUND_CHECK_EN adds an out-of-range fault.
// Ports: clk, rstN, instr (memory word for pcCurrent), stall, redirectValid,
//        redirectPc, pcCurrent, ifInstr, ifPcPlus1, ifValid, halted, fetchFault.
module fetch_unit
    import lc2k_pkg::*;
#(
    parameter int unsigned PC_W      = 16,
    parameter int unsigned MEM_DEPTH = 9,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic [INSTR_W-1:0] instr,
    input  logic               stall,
    input  logic               redirectValid,
    input  logic [PC_W-1:0]    redirectPc,
    output logic [PC_W-1:0]    pcCurrent,
    output logic [INSTR_W-1:0] ifInstr,
    output logic [PC_W-1:0]    ifPcPlus1,
    output logic               ifValid,
    output logic               halted,
    output logic               fetchFault
);

    // Memory depth must be addressable by the PC.
    if (MEM_DEPTH == 0 || 64'(MEM_DEPTH) > (64'(1) << PC_W)) begin : g_bad_depth
        $error("fetch_unit: MEM_DEPTH out of range for PC_W");
    end

    fetch_state_e      state, state_next;
    logic [PC_W-1:0]   pc_next;
    logic [PC_W-1:0]   pc_plus1;
    logic              halted_next;
    logic              fault_next;
    logic              load;
    logic              flush;

    // Truncating add: all-ones wraps to zero.
    assign pc_plus1 = PC_W'(pcCurrent + PC_W'(1));

    // Next-state and control decode, in priority order redirect > stall > state.
    always_comb begin
        state_next  = state;
        pc_next     = pcCurrent;
        halted_next = halted;
        fault_next  = fetchFault;
        load        = 1'b0;
        flush       = 1'b0;
        if (redirectValid) begin
            pc_next     = redirectPc;
            flush       = 1'b1;
            state_next  = ST_RUN;
            halted_next = 1'b0;
            fault_next  = 1'b0;
        end else if (!stall) begin
            case (state)
                ST_RUN: begin
`ifdef FETCH_BOUND_CHECK_EN
                    if (32'(pcCurrent) >= 32'(MEM_DEPTH)) begin
                        flush      = 1'b1;
                        fault_next = 1'b1;
                        state_next = ST_FAULT;
                    end else
`endif
                    begin
                        load = 1'b1;
                        if (is_halt(instr)) begin
                            state_next  = ST_HALTED;
                            halted_next = 1'b1;
                        end else begin
                            pc_next = pc_plus1;
                        end
                    end
                end
                // HALTED and FAULT both park the PC and emit bubbles.
                default: flush = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= ST_RUN;
            pcCurrent <= PC_W'(RESET_PC);
            halted    <= 1'b0;
        end else begin
            state     <= state_next;
            pcCurrent <= pc_next;
            halted    <= halted_next;
        end
    end

`ifdef FETCH_BOUND_CHECK_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fetchFault <= 1'b0;
        end else begin
            fetchFault <= fault_next;
        end
    end
`else
    assign fetchFault = 1'b0;
`endif

    if_id_reg #(
        .PC_W (PC_W)
    ) u_if_id (
        .clk       (clk),
        .rstN      (rstN),
        .load      (load),
        .flush     (flush),
        .instrIn   (instr),
        .pcPlus1In (pc_plus1),
        .ifInstr   (ifInstr),
        .ifPcPlus1 (ifPcPlus1),
        .ifValid   (ifValid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] instr;
    logic        stall;
    logic        redirectValid;
    logic [15:0] redirectPc;
    logic [15:0] pcCurrent;
    logic [31:0] ifInstr;
    logic [15:0] ifPcPlus1;
    logic        ifValid;
    logic        halted;
    logic        fetchFault;

    logic        w_redirectValid;
    logic [3:0]  w_redirectPc;
    logic [3:0]  w_pcCurrent;
    logic [31:0] w_ifInstr;
    logic [3:0]  w_ifPcPlus1;
    logic        w_ifValid;
    logic        w_halted;
    logic        w_fetchFault;

    logic [31:0] mem [0:8];
    int total = 0;
    int bad   = 0;

    localparam logic [31:0] HALT_W = 32'd25165824;

    always #5 clk = ~clk;

    always_comb begin
        instr = 32'h0;
        if (pcCurrent < 16'd9) instr = mem[pcCurrent[3:0]];
    end

    fetch_unit dut (
        .clk(clk), .rstN(rstN), .instr(instr), .stall(stall),
        .redirectValid(redirectValid), .redirectPc(redirectPc),
        .pcCurrent(pcCurrent), .ifInstr(ifInstr), .ifPcPlus1(ifPcPlus1),
        .ifValid(ifValid), .halted(halted), .fetchFault(fetchFault)
    );

    fetch_unit #(.PC_W(4)) dut_w (
        .clk(clk), .rstN(rstN), .instr(32'h0000_0001), .stall(1'b0),
        .redirectValid(w_redirectValid), .redirectPc(w_redirectPc),
        .pcCurrent(w_pcCurrent), .ifInstr(w_ifInstr), .ifPcPlus1(w_ifPcPlus1),
        .ifValid(w_ifValid), .halted(w_halted), .fetchFault(w_fetchFault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},    32'(pcCurrent), 32'd0);
        chk({tag, "_instr"}, ifInstr,        32'd0);
        chk({tag, "_pcp1"},  32'(ifPcPlus1), 32'd0);
        chk({tag, "_valid"}, 32'(ifValid),   32'd0);
        chk({tag, "_halt"},  32'(halted),    32'd0);
        chk({tag, "_fault"}, 32'(fetchFault), 32'd0);
        chk({tag, "_wpc"},   32'(w_pcCurrent), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 9; i++) mem[i] = 32'h0001_0000 + 32'(i);
        mem[2] = 32'd29360128;
        mem[6] = 32'd655361;
        mem[8] = HALT_W;
        rstN = 1'b0; stall = 1'b0; redirectValid = 1'b0; redirectPc = '0;
        w_redirectValid = 1'b0; w_redirectPc = '0;

        #2;
        chk_reset("rst");
        @(negedge clk);
        rstN = 1'b1;

        // Straight-line run through the program to the halt.
        step();
        chk("run1_valid", 32'(ifValid), 32'd1);
        chk("run1_instr", ifInstr, mem[0]);
        chk("run1_pcp1", 32'(ifPcPlus1), 32'd1);
        chk("run1_pc", 32'(pcCurrent), 32'd1);
        for (int k = 2; k <= 8; k++) begin
            step();
            chk("run_pc", 32'(pcCurrent), 32'(k));
            chk("run_instr", ifInstr, mem[k-1]);
        end
        step();
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pcCurrent), 32'd8);
        chk("halt_instr", ifInstr, HALT_W);
        chk("halt_pcp1", 32'(ifPcPlus1), 32'd9);
        chk("halt_valid", 32'(ifValid), 32'd1);
        step();
        chk("halt2_valid", 32'(ifValid), 32'd0);
        chk("halt2_pc", 32'(pcCurrent), 32'd8);
        chk("halt2_flag", 32'(halted), 32'd1);
        step();
        chk("halt3_pc", 32'(pcCurrent), 32'd8);
        chk("halt3_flag", 32'(halted), 32'd1);

        // Redirect out of HALTED.
        redirectValid = 1'b1; redirectPc = 16'd4;
        step();
        chk("unhalt_flag", 32'(halted), 32'd0);
        chk("unhalt_pc", 32'(pcCurrent), 32'd4);
        chk("unhalt_valid", 32'(ifValid), 32'd0);
        chk("unhalt_hold", ifInstr, HALT_W);
        redirectValid = 1'b0;
        step();
        chk("restart_instr", ifInstr, mem[4]);
        chk("restart_valid", 32'(ifValid), 32'd1);
        chk("restart_pc", 32'(pcCurrent), 32'd5);
        chk("restart_pcp1", 32'(ifPcPlus1), 32'd5);

        // Stall for three cycles at pc=3.
        redirectValid = 1'b1; redirectPc = 16'd2;
        step();
        redirectValid = 1'b0;
        step();
        chk("pre_stall_pc", 32'(pcCurrent), 32'd3);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_pc", 32'(pcCurrent), 32'd3);
            chk("stall_instr", ifInstr, 32'd29360128);
            chk("stall_valid", 32'(ifValid), 32'd1);
        end
        stall = 1'b0;
        step();
        chk("resume_instr", ifInstr, mem[3]);
        chk("resume_pc", 32'(pcCurrent), 32'd4);

        // Redirect concurrent with stall.
        redirectValid = 1'b1; redirectPc = 16'd2;
        step();
        chk("rs_pre_pc", 32'(pcCurrent), 32'd2);
        stall = 1'b1; redirectPc = 16'd6;
        step();
        chk("rs_pc", 32'(pcCurrent), 32'd6);
        chk("rs_valid", 32'(ifValid), 32'd0);
        stall = 1'b0; redirectValid = 1'b0;
        step();
        chk("rs_instr", ifInstr, 32'd655361);
        chk("rs_valid2", 32'(ifValid), 32'd1);
        chk("rs_pc2", 32'(pcCurrent), 32'd7);

        // Stall while a halt word is presented.
        redirectValid = 1'b1; redirectPc = 16'd8;
        step();
        redirectValid = 1'b0; stall = 1'b1;
        step();
        chk("sh_flag", 32'(halted), 32'd0);
        chk("sh_valid", 32'(ifValid), 32'd0);
        chk("sh_pc", 32'(pcCurrent), 32'd8);
        stall = 1'b0;
        step();
        chk("sh_flag2", 32'(halted), 32'd1);
        chk("sh_instr", ifInstr, HALT_W);

        // Asynchronous reset while halted and stalled.
        stall = 1'b1;
        step();
        #2;
        rstN = 1'b0;
        #1;
        chk_reset("rst2");
        @(negedge clk);
        rstN = 1'b1; stall = 1'b0;

        // PC wrap on the 4-bit instance.
        w_redirectValid = 1'b1; w_redirectPc = 4'd15;
        step();
        chk("wrap_pre_pc", 32'(w_pcCurrent), 32'd15);
        w_redirectValid = 1'b0;
        step();
        chk("wrap_pc", 32'(w_pcCurrent), 32'd0);
        chk("wrap_pcp1", 32'(w_ifPcPlus1), 32'd0);
        chk("wrap_valid", 32'(w_ifValid), 32'd1);

        // Fetch beyond the program.
        redirectValid = 1'b1; redirectPc = 16'd9;
        step();
        chk("oob_pre_pc", 32'(pcCurrent), 32'd9);
        chk("oob_pre_fault", 32'(fetchFault), 32'd0);
        redirectValid = 1'b0;
        step();
`ifdef FETCH_BOUND_CHECK_EN
        chk("oob_fault", 32'(fetchFault), 32'd1);
        chk("oob_valid", 32'(ifValid), 32'd0);
        chk("oob_pc", 32'(pcCurrent), 32'd9);
        step();
        chk("oob_fault2", 32'(fetchFault), 32'd1);
        chk("oob_pc2", 32'(pcCurrent), 32'd9);
`else
        chk("oob_fault", 32'(fetchFault), 32'd0);
        chk("oob_valid", 32'(ifValid), 32'd1);
        chk("oob_instr", ifInstr, 32'd0);
        chk("oob_pc", 32'(pcCurrent), 32'd10);
        step();
        chk("oob_fault2", 32'(fetchFault), 32'd0);
`endif
        redirectValid = 1'b1; redirectPc = 16'd0;
        step();
        chk("clr_fault", 32'(fetchFault), 32'd0);
        chk("clr_pc", 32'(pcCurrent), 32'd0);
        chk("clr_valid", 32'(ifValid), 32'd0);
        redirectValid = 1'b0;
        step();
        chk("clr_valid2", 32'(ifValid), 32'd1);
        chk("clr_instr", ifInstr, mem[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
